// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
// Contents: FSM state enum, word width, latency bound, latency counter type.
// Optional feature macro used by this slice: DMEM_BYTE_STROBE_EN.
package dmem_pkg;

  localparam int WORD_W      = 32;
  localparam int MAX_LATENCY = 15;

  // Wide enough to hold MAX_LATENCY-1.
  typedef logic [3:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port DEPTH x 32 word RAM, byte write enables, registered read
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (clears rdata only, not the array)
//   re     in   read strobe: rdata <= mem[addr]
//   clr    in   force rdata to zero (misaligned load)
//   we     in   per-byte write enable, bit i covers wdata[8i+7:8i]
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data, holds between reads
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic              clr,
  input  logic [3:0]        we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency responder for the core data-memory interface
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   MemReq     in   request valid
//   MemWrite   in   1 = store, 0 = load (sampled on accept)
//   Addr       in   byte address (sampled on accept)
//   WriteData  in   store data (sampled on accept)
//   ByteEn     in   store lane enables (only with DMEM_BYTE_STROBE_EN)
//   MemReady   out  request can be accepted this cycle
//   MemDone    out  one-cycle completion pulse
//   ReadData   out  load result, held until the next load completes
//   MemErr     out  qualifies MemDone: misaligned, not performed
// Optional feature macro: DMEM_BYTE_STROBE_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReq,
  input  logic              MemWrite,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WriteData,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]        ByteEn,
`endif
  output logic              MemReady,
  output logic              MemDone,
  output logic [WORD_W-1:0] ReadData,
  output logic              MemErr
);

  localparam int AW = $clog2(DEPTH);

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   enter_resp;
  logic   accept;
  logic   err_q;

  logic [AW+1:0]     addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              write_q;
  logic [3:0]        be_q;
  logic [3:0]        be_in;

  logic              use_latched;
  logic [AW+1:0]     acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic              acc_write;
  logic [3:0]        acc_be;
  logic              mis;

  logic              ram_re;
  logic              ram_clr;
  logic [3:0]        ram_we;

  // Upper address bits wrap away by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[31:AW+2];

`ifdef DMEM_BYTE_STROBE_EN
  assign be_in = ByteEn;
`else
  assign be_in = 4'hF;
`endif

  assign MemReady = (state_q != WAIT);
  assign MemDone  = (state_q == RESP);
  assign MemErr   = (state_q == RESP) && err_q;
  assign accept   = MemReq && MemReady;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          cnt_d = cnt_t'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - cnt_t'(1);
        if (cnt_q == cnt_t'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The access is performed on the edge that enters RESP. From WAIT the
  // latched request is used; with LATENCY==1 that edge is also the accept
  // edge, so the live inputs are used instead.
  always_comb begin
    use_latched = (state_q == WAIT);
    acc_addr    = use_latched ? addr_q  : Addr[AW+1:0];
    acc_wdata   = use_latched ? wdata_q : WriteData;
    acc_write   = use_latched ? write_q : MemWrite;
    acc_be      = use_latched ? be_q    : be_in;
`ifdef DMEM_BYTE_STROBE_EN
    mis = (acc_addr[1:0] != 2'b00) && (acc_be == 4'hF);
`else
    mis = (acc_addr[1:0] != 2'b00);
`endif
  end

  // Reset on the commit edge abandons the access, including a pending store.
  assign ram_re  = enter_resp && !reset && !acc_write && !mis;
  assign ram_clr = enter_resp && !acc_write && mis;
  assign ram_we  = (enter_resp && !reset && acc_write && !mis) ? acc_be : 4'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        err_q <= mis;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= Addr[AW+1:0];
      wdata_q <= WriteData;
      write_q <= MemWrite;
      be_q    <= be_in;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .re    (ram_re),
    .clr   (ram_clr),
    .we    (ram_we),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (ReadData)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (DEPTH=64, LATENCY=2)
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [3:0]  ByteEn;
  logic        MemReady;
  logic        MemDone;
  logic [31:0] ReadData;
  logic        MemErr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
`ifdef DMEM_BYTE_STROBE_EN
    .ByteEn    (ByteEn),
`endif
    .MemReady  (MemReady),
    .MemDone   (MemDone),
    .ReadData  (ReadData),
    .MemErr    (MemErr)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete access: request at a negedge, accept on the next posedge
  // where MemReady is high, then check the LAT-cycle response window.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic [31:0] exp_rd,
                           input logic exp_err, input string nm);
    int g;
    @(negedge clk);
    MemReq = 1'b1; MemWrite = w; Addr = a; WriteData = d; ByteEn = be;
    g = 0;
    while (!MemReady && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) begin
      n_chk++; n_fail++;
      $display("FAIL %s_ready_timeout: got 0 expected 1", nm);
    end
    @(posedge clk);
    #1;
    // Scramble the request inputs: the responder must use its latched copy.
    MemReq = 1'b0; MemWrite = ~w; Addr = 32'hFFFF_FFFF; WriteData = ~d; ByteEn = 4'h0;
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      chk({nm, "_wait_ready"}, {31'b0, MemReady}, 32'd0);
      chk({nm, "_wait_done"},  {31'b0, MemDone},  32'd0);
    end
    @(negedge clk);
    chk({nm, "_done"},  {31'b0, MemDone}, 32'd1);
    chk({nm, "_err"},   {31'b0, MemErr},  {31'b0, exp_err});
    chk({nm, "_rdata"}, ReadData, exp_rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;

    //                w     addr          wdata         be    exp ReadData  err
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         4'hF, 32'h0000_0000, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 32'hCAFE_F00D, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0021, 32'hFFFF_FFFF, 4'hF, 32'hCAFE_F00D, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h1234_5678, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_003C, 32'h0BAD_F00D, 4'hF, 32'h1234_5678, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_013C, 32'h0,         4'hF, 32'h0BAD_F00D, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_00FE, 32'h0,         4'hF, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_023C, 32'h0,         4'hF, 32'h0BAD_F00D, 1'b0};

    reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0; ByteEn = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, MemReady}, 32'd1);
    chk("rst_done",  {31'b0, MemDone},  32'd0);
    chk("rst_rdata", ReadData,          32'd0);
    chk("rst_err",   {31'b0, MemErr},   32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].be, vecs[i].rd, vecs[i].err,
                $sformatf("vec%0d", i));
    end

    // Store then load accepted in the store's RESP cycle, MemReq held high.
    @(negedge clk);
    MemReq = 1'b1; MemWrite = 1'b1; Addr = 32'h4; WriteData = 32'h1111_1111; ByteEn = 4'hF;
    chk("b2b_idle_ready", {31'b0, MemReady}, 32'd1);
    @(negedge clk);
    chk("b2b_st_wait_ready", {31'b0, MemReady}, 32'd0);
    MemWrite = 1'b0; WriteData = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("b2b_st_done",  {31'b0, MemDone},  32'd1);
    chk("b2b_st_err",   {31'b0, MemErr},   32'd0);
    chk("b2b_st_ready", {31'b0, MemReady}, 32'd1);
    @(negedge clk);
    chk("b2b_ld_wait_ready", {31'b0, MemReady}, 32'd0);
    chk("b2b_ld_wait_done",  {31'b0, MemDone},  32'd0);
    @(negedge clk);
    chk("b2b_ld_done",  {31'b0, MemDone}, 32'd1);
    chk("b2b_ld_rdata", ReadData, 32'h1111_1111);
    MemReq = 1'b0;
    @(negedge clk);
    chk("b2b_after_done",  {31'b0, MemDone},  32'd0);
    chk("b2b_after_ready", {31'b0, MemReady}, 32'd1);

    // Reset during WAIT abandons the store.
    @(negedge clk);
    MemReq = 1'b1; MemWrite = 1'b1; Addr = 32'h20; WriteData = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    MemReq = 1'b0;
    @(negedge clk);
    chk("rstw_wait_ready", {31'b0, MemReady}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_done",  {31'b0, MemDone},  32'd0);
    chk("rstw_ready", {31'b0, MemReady}, 32'd1);
    chk("rstw_rdata", ReadData,          32'd0);
    chk("rstw_err",   {31'b0, MemErr},   32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (MemDone) seen = 1'b1;
    end
    chk("rstw_no_done", {31'b0, seen}, 32'd0);
    do_access(1'b0, 32'h20, 32'h0, 4'hF, 32'h1234_5678, 1'b0, "rstw_reload");

`ifdef DMEM_BYTE_STROBE_EN
    do_access(1'b1, 32'h08, 32'hAABB_CCDD, 4'hF,    32'h1234_5678, 1'b0, "be_full");
    do_access(1'b1, 32'h08, 32'h0000_0011, 4'b0001, 32'h1234_5678, 1'b0, "be_lane0");
    do_access(1'b0, 32'h08, 32'h0,         4'h0,    32'hAABB_CC11, 1'b0, "be_load");
    do_access(1'b1, 32'h08, 32'hFFFF_FFFF, 4'b0000, 32'hAABB_CC11, 1'b0, "be_none");
    do_access(1'b0, 32'h08, 32'h0,         4'hF,    32'hAABB_CC11, 1'b0, "be_load2");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
